// File: rtl/fifo_mem_ctrl.sv
// First-word-fall-through FIFO built around a 1R1W memory with registered read data.
// Latency: a push accepted at edge E0 is presented on pop_data after E2 (3 cycles), 1 word/cycle sustained.
// Backpressure: push_ready drops while the memory is full; pop side holds data until pop_ready.
module fifo_mem_ctrl #(
  parameter int data_width = 32,
  parameter int mem_depth  = 16,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [data_width-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [data_width-1:0] pop_data,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_waddr,
  output logic [data_width-1:0] mem_wdata,
  output logic                  mem_re,
  output logic [addr_width-1:0] mem_raddr,
  input  logic [data_width-1:0] mem_rdata,
  output logic [addr_width+1:0] level
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = addr_width + 1;
  localparam int LW = addr_width + 2;
  // With mem_depth == 2**addr_width, a difference equal to the depth means
  // the wrap bits differ while the address bits match, i.e. memory full.
  localparam logic [PW-1:0] MEM_DEPTH_C = PW'(mem_depth);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  buf_head_q, buf_head_d;
  logic [data_width-1:0] buf_q [2];
  logic [data_width-1:0] buf_d [2];

  logic [PW-1:0] mem_count;
  logic          mem_full;
  logic          mem_empty;
  logic          push_fire;
  logic          pop_fire;
  logic          fetch;
  logic [2:0]    buf_occ;
  logic          cap_slot;

  assign mem_count = wr_ptr_q - rd_ptr_q;
  assign mem_full  = (mem_count == MEM_DEPTH_C);
  assign mem_empty = (wr_ptr_q == rd_ptr_q);

  // Producer is refused while flushing or in reset so no word is
  // reported as accepted and then silently dropped.
  assign push_ready = !mem_full && !flush && !reset;
  assign push_fire  = push_valid && push_ready;

  assign mem_we    = push_fire;
  assign mem_waddr = wr_ptr_q[addr_width-1:0];
  assign mem_wdata = push_data;

  assign pop_valid = (buf_cnt_q != 2'd0);
  assign pop_data  = buf_q[buf_head_q];
  assign pop_fire  = pop_valid && pop_ready && !flush;

  // Occupancy the buffer will have once the in-flight word lands; a new
  // read is issued only if that still leaves a free slot after this pop.
  assign buf_occ = 3'(buf_cnt_q) + 3'(inflight_q);
  assign fetch   = !mem_empty && !flush && !reset &&
                   (buf_occ < (3'd2 + 3'(pop_fire)));

  assign mem_re    = fetch;
  assign mem_raddr = rd_ptr_q[addr_width-1:0];

  // A capture never sees a full buffer, so the tail slot is head + count.
  assign cap_slot = buf_head_q ^ buf_cnt_q[0];

  assign level = LW'(mem_count) + LW'(inflight_q) + LW'(buf_cnt_q);

  // Next-state: flush clears everything and overrides push, pop and capture.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = inflight_q;
    buf_cnt_d  = buf_cnt_q;
    buf_head_d = buf_head_q;
    buf_d      = buf_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
      buf_cnt_d  = 2'd0;
      buf_head_d = 1'b0;
      buf_d[0]   = '0;
      buf_d[1]   = '0;
    end else begin
      if (push_fire) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (fetch) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      inflight_d = fetch;
      if (inflight_q) begin
        buf_d[cap_slot] = mem_rdata;
      end
      if (pop_fire) begin
        buf_head_d = ~buf_head_q;
      end
      buf_cnt_d = buf_cnt_q + 2'(inflight_q) - 2'(pop_fire);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf_head_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf_head_q <= buf_head_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
    end
  end

endmodule
